// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FPU datapath blocks.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BIAS   = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    NORM  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam fp32_t FP_ZERO = '{sign: 1'b0, exp: '0,      frac: '0};
  localparam fp32_t FP_INF  = '{sign: 1'b0, exp: EXP_MAX, frac: '0};

endpackage

// File: rtl/fp_unpack.sv
// Splits a binary32 word into sign, exponent and a 25-bit working fraction
// (carry guard bit, hidden bit, stored fraction). Denormals flush to zero.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       i_op,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [FRAC_W+1:0] o_frac
);

  // Field split with flush-to-zero of exponent-zero operands.
  always_comb begin
    o_sign = i_op[31];
    o_exp  = i_op[30:23];
    o_frac = (i_op[30:23] != '0) ? {2'b01, i_op[22:0]} : '0;
  end

endmodule

// File: rtl/fsub_iter.sv
// Multi-cycle binary32 subtractor, out = a - b. Truncating, flush-to-zero,
// zero on exponent underflow. Normalisation shifts one bit per cycle.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   ALIGN | order by magnitude, align smaller fraction, add or subtract
//   NORM  | one carry/left-shift step per cycle until normalised
//   DONE  | result presented, waiting for out_ready
module fsub_iter
  import fp_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  if (EXP_W != fp_pkg::EXP_W || FRAC_W != fp_pkg::FRAC_W) begin : g_bad_param
    $error("fsub_iter supports binary32 only (EXP_W=8, FRAC_W=23)");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [FRAC_W+1:0] r_frac;
  logic [EXP_W-1:0]  r_exp;
  logic              r_sign;
  fp32_t             r_out;

  logic              w_sa, w_sb;
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W+1:0] w_fa, w_fb;

  logic              w_swap;
  logic              w_sl, w_ss;
  logic [EXP_W-1:0]  w_el, w_es, w_exp_diff;
  logic [FRAC_W+1:0] w_fl, w_fs, w_fs_sh, w_sum;

  logic [FRAC_W+1:0] w_frac_rsh;
  logic [EXP_W-1:0]  w_exp_inc, w_exp_dec;
  logic              w_norm_done;

  // r_b holds b with its sign already flipped, so ALIGN sees a + (-b).
  fp_unpack u_unpack_a (
    .i_op   (r_a),
    .o_sign (w_sa),
    .o_exp  (w_ea),
    .o_frac (w_fa)
  );

  fp_unpack u_unpack_b (
    .i_op   (r_b),
    .o_sign (w_sb),
    .o_exp  (w_eb),
    .o_frac (w_fb)
  );

  // Magnitude ordering, alignment shift and signed fraction combine.
  always_comb begin
    w_swap     = (r_a[30:0] < r_b[30:0]);
    w_sl       = w_swap ? w_sb : w_sa;
    w_ss       = w_swap ? w_sa : w_sb;
    w_el       = w_swap ? w_eb : w_ea;
    w_es       = w_swap ? w_ea : w_eb;
    w_fl       = w_swap ? w_fb : w_fa;
    w_fs       = w_swap ? w_fa : w_fb;
    w_exp_diff = w_el - w_es;
    w_fs_sh    = (w_exp_diff >= 8'd25) ? '0 : (w_fs >> w_exp_diff);
    w_sum      = (w_sl != w_ss) ? (w_fl - w_fs_sh) : (w_fl + w_fs_sh);
  end

  // Single normalisation step helpers and the NORM exit condition.
  always_comb begin
    w_frac_rsh  = r_frac >> 1;
    w_exp_inc   = r_exp + 8'd1;
    w_exp_dec   = r_exp - 8'd1;
    w_norm_done = (r_frac == '0) || r_frac[FRAC_W+1] || r_frac[FRAC_W] ||
                  (w_exp_dec == '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_state_nxt = ALIGN;
      ALIGN:                    w_state_nxt = NORM;
      NORM:    if (w_norm_done) w_state_nxt = DONE;
      DONE:    if (out_ready)   w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out       = r_out;
  end

  // Datapath: capture, align/combine, then one normalisation action per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_frac <= '0;
      r_exp  <= '0;
      r_sign <= 1'b0;
      r_out  <= FP_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= a;
            r_b <= {~b[31], b[30:0]};
          end
        end
        ALIGN: begin
          r_frac <= w_sum;
          r_exp  <= w_el;
          r_sign <= w_sl;
        end
        NORM: begin
          if (r_frac == '0) begin
            r_out <= FP_ZERO;
          end else if (r_frac[FRAC_W+1]) begin
            // Carry out: after the right shift the hidden bit is set, so the
            // result is final this cycle unless the exponent overflowed.
            r_frac <= w_frac_rsh;
            r_exp  <= w_exp_inc;
            if (w_exp_inc == EXP_MAX)
              r_out <= '{sign: r_sign, exp: EXP_MAX, frac: '0};
            else
              r_out <= '{sign: r_sign, exp: w_exp_inc, frac: w_frac_rsh[FRAC_W-1:0]};
          end else if (r_frac[FRAC_W]) begin
            if (r_exp == '0)
              r_out <= FP_ZERO;
            else
              r_out <= '{sign: r_sign, exp: r_exp, frac: r_frac[FRAC_W-1:0]};
          end else begin
            r_frac <= r_frac << 1;
            r_exp  <= w_exp_dec;
            if (w_exp_dec == '0) r_out <= FP_ZERO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
